io_port_router: RTL



---
 rtl/io_router_pkg.sv | 47 ++++
 rtl/io_port_map.sv | 11 +
 rtl/io_port_router.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/io_router_pkg.sv
// Shared types and the port-ID map for the PicoBlaze I/O router.
// The io_map table is the single place where port IDs are allocated to channels.
package io_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE
  } state_t;

  localparam logic [7:0] STATUS_ID_DEF = 8'hFF;
  localparam logic [7:0] DATA_ID_DEF   = 8'hFE;

  localparam logic [2:0] CH_RTC = 3'd0;
  localparam logic [2:0] CH_KBD = 3'd1;
  localparam logic [2:0] CH_VGA = 3'd2;
  localparam logic [2:0] CH_SND = 3'd3;

  typedef struct packed {
    logic       hit;
    logic [2:0] ch;
    logic [7:0] addr;
  } io_map_t;

  // RTC time registers sit in two banks (0x21.. and 0x41..); the VGA window
  // is mirrored so the highest port ID lands on the lowest register.
  function automatic io_map_t io_map(input logic [7:0] id);
    io_map_t m;
    m = '{hit: 1'b0, ch: CH_RTC, addr: 8'h00};
    if (id >= 8'd1 && id <= 8'd4)
      m = '{hit: 1'b1, ch: CH_RTC, addr: 8'hF4 - id};
    else if (id >= 8'd5 && id <= 8'd7)
      m = '{hit: 1'b1, ch: CH_KBD, addr: id - 8'd5};
    else if (id == 8'd11)
      m = '{hit: 1'b1, ch: CH_RTC, addr: 8'h10};
    else if (id == 8'd14)
      m = '{hit: 1'b1, ch: CH_SND, addr: 8'h00};
    else if (id >= 8'd17 && id <= 8'd22)
      m = '{hit: 1'b1, ch: CH_RTC, addr: 8'h21 + (id - 8'd17)};
    else if (id >= 8'd23 && id <= 8'd28)
      m = '{hit: 1'b1, ch: CH_RTC, addr: 8'h41 + (id - 8'd23)};
    else if (id >= 8'd40 && id <= 8'd51)
      m = '{hit: 1'b1, ch: CH_VGA, addr: 8'd88 - id};
    return m;
  endfunction

endpackage

// File: rtl/io_port_map.sv
// Combinational port-ID decoder; wraps io_map so a build can swap the table.
module io_port_map
  import io_router_pkg::*;
(
  input  logic [7:0] port_id,
  output io_map_t    entry
);

  assign entry = io_map(port_id);

endmodule

// File: rtl/io_port_router.sv
// Registered, handshaked PicoBlaze port router.
// Optional feature macro: IO_ROUTER_TIMEOUT_EN enables the REQ timeout counter;
// without it REQ waits for ch_ack indefinitely and to_flag stays 0.
module io_port_router
  import io_router_pkg::*;
#(
  parameter int         N_CH      = 4,
  parameter int         ADDR_W    = 8,
  parameter int         TIMEOUT   = 255,
  parameter logic [7:0] STATUS_ID = STATUS_ID_DEF,
  parameter logic [7:0] DATA_ID   = DATA_ID_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          port_id,
  input  logic                write_strobe,
  input  logic                read_strobe,
  input  logic [7:0]          out_port,
  output logic [7:0]          in_port,
  output logic [N_CH-1:0]     ch_sel,
  output logic [ADDR_W-1:0]   ch_addr,
  output logic                ch_we,
  output logic [7:0]          ch_wdata,
  output logic                ch_req,
  input  logic [N_CH-1:0]     ch_ack,
  input  logic [N_CH*8-1:0]   ch_rdata,
  output logic                busy,
  output logic                err
);

  if (N_CH < 1 || N_CH > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
    $error("io_port_router: N_CH or TIMEOUT out of range");
  end

  io_map_t    map_e;
  state_t     state;
  logic       to_flag;
  logic       ovr_flag;
  logic [7:0] rdata_q;
  logic       strobe;
  logic       hit;
  logic       ack_hit;
  logic       ovr_set;
  logic       to_set;
  logic       status_clr;
  logic [7:0] sel_rdata;
  logic [7:0] status;

`ifdef IO_ROUTER_TIMEOUT_EN
  localparam logic [15:0] TO_LOAD = 16'(TIMEOUT - 1);
  logic [15:0] to_cnt;
`endif

  io_port_map u_map (
    .port_id (port_id),
    .entry   (map_e)
  );

  // Decode strobes, honour only the selected ack, and pick the selected channel's read data.
  always_comb begin
    strobe     = read_strobe | write_strobe;
    hit        = map_e.hit && (int'(map_e.ch) < N_CH) &&
                 (port_id != STATUS_ID) && (port_id != DATA_ID);
    ack_hit    = |(ch_ack & ch_sel);
    ovr_set    = strobe && hit && (state != ST_IDLE);
    status_clr = write_strobe && (port_id == STATUS_ID);
    status     = {busy, err, to_flag, ovr_flag, 4'b0000};
    sel_rdata  = 8'h00;
    for (int k = 0; k < N_CH; k++) begin
      if (ch_sel[k]) sel_rdata = sel_rdata | ch_rdata[8*k +: 8];
    end
`ifdef IO_ROUTER_TIMEOUT_EN
    to_set = (state == ST_REQ) && !ack_hit && (to_cnt == 16'd0);
`else
    to_set = 1'b0;
`endif
  end

  // Transaction FSM with registered channel outputs and sticky error flags; a new error beats a status clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ch_req   <= 1'b0;
      busy     <= 1'b0;
      ch_we    <= 1'b0;
      ch_sel   <= '0;
      ch_addr  <= '0;
      ch_wdata <= 8'h00;
      rdata_q  <= 8'h00;
      err      <= 1'b0;
      to_flag  <= 1'b0;
      ovr_flag <= 1'b0;
`ifdef IO_ROUTER_TIMEOUT_EN
      to_cnt   <= 16'd0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (strobe && hit) begin
            state    <= ST_REQ;
            ch_req   <= 1'b1;
            busy     <= 1'b1;
            ch_sel   <= N_CH'(1) << map_e.ch;
            ch_addr  <= ADDR_W'(map_e.addr);
            ch_we    <= write_strobe;
            ch_wdata <= out_port;
`ifdef IO_ROUTER_TIMEOUT_EN
            to_cnt   <= TO_LOAD;
`endif
          end
        end
        ST_REQ: begin
          if (ack_hit) begin
            state  <= ST_DONE;
            ch_req <= 1'b0;
            if (!ch_we) rdata_q <= sel_rdata;
          end else if (to_set) begin
            state   <= ST_DONE;
            ch_req  <= 1'b0;
            rdata_q <= 8'h00;
          end
`ifdef IO_ROUTER_TIMEOUT_EN
          else begin
            to_cnt <= to_cnt - 16'd1;
          end
`endif
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
      err      <= (err & ~status_clr) | to_set | ovr_set;
      to_flag  <= (to_flag & ~status_clr) | to_set;
      ovr_flag <= (ovr_flag & ~status_clr) | ovr_set;
    end
  end

  // Read-back mux, registered every cycle from the current port_id.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_port <= 8'h00;
    end else if (port_id == STATUS_ID) begin
      in_port <= status;
    end else if (port_id == DATA_ID) begin
      in_port <= rdata_q;
    end else begin
      in_port <= 8'h00;
    end
  end

endmodule
